// File: rtl/text_buf_writer_arb.sv
// Round-robin arbiter that streams client strings into the 16x16 char buffer.
// One char per valid/ready handshake; writes optionally held to vblank.
module text_buf_writer_arb #(
   parameter int N_REQ      = 3,
   parameter bit BLANK_ONLY = 1'b1
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [N_REQ-1:0]   req_i,
   input  logic [N_REQ*8-1:0] start_xy_i,
   input  logic [N_REQ*5-1:0] len_i,
   input  logic [N_REQ*7-1:0] char_i,
   input  logic [N_REQ-1:0]   valid_i,
   output logic [N_REQ-1:0]   ready_o,
   output logic [N_REQ-1:0]   done_o,
   output logic               busy_o,
   input  logic               vblank_i,
   output logic               buf_we_o,
   output logic [7:0]         buf_addr_o,
   output logic [6:0]         buf_data_o
);

   localparam int GW = $clog2(N_REQ);

   typedef enum logic [1:0] {IDLE, LOAD, XFER, DONE} state_t;

   state_t        state, state_nx;
   logic [GW-1:0] rr_ptr, gnt, pick, gnt_inc;
   logic [7:0]    addr;
   logic [4:0]    cnt;
   logic          write_ok, hs;
   logic          req_g, valid_g;
   logic [6:0]    char_g;
   logic [7:0]    xy_g;
   logic [4:0]    len_g, len_c;

   assign req_g    = req_i[gnt];
   assign valid_g  = valid_i[gnt];
   assign char_g   = char_i[7*int'(gnt) +: 7];
   assign xy_g     = start_xy_i[8*int'(gnt) +: 8];
   assign len_g    = len_i[5*int'(gnt) +: 5];
   assign len_c    = (len_g > 5'd16) ? 5'd16 : len_g;
   assign write_ok = !BLANK_ONLY || vblank_i;
   assign hs       = (state == XFER) && req_g && write_ok && valid_g;
   assign gnt_inc  = (int'(gnt) == N_REQ-1) ? '0 : gnt + 1'b1;
   assign busy_o   = (state != IDLE);

   // first requester at or after rr_ptr, wrapping
   always_comb begin
      int  idx;
      logic found;
      pick  = rr_ptr;
      found = 1'b0;
      for (int i = 0; i < N_REQ; i++) begin
         idx = (int'(rr_ptr) + i) % N_REQ;
         if (!found && req_i[idx]) begin
            pick  = GW'(idx);
            found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nx = state;
      ready_o  = '0;
      done_o   = '0;
      unique case (state)
         IDLE: if (|req_i) state_nx = LOAD;
         LOAD: state_nx = (len_c == 5'd0) ? DONE : XFER;
         XFER: begin
            if (!req_g) begin
               state_nx = IDLE;
            end else begin
               ready_o[gnt] = write_ok;
               if (hs && cnt == 5'd1) state_nx = DONE;
            end
         end
         DONE: begin
            done_o[gnt] = 1'b1;
            state_nx    = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state      <= IDLE;
         rr_ptr     <= '0;
         gnt        <= '0;
         addr       <= '0;
         cnt        <= '0;
         buf_we_o   <= 1'b0;
         buf_addr_o <= '0;
         buf_data_o <= '0;
      end else begin
         state    <= state_nx;
         buf_we_o <= hs;
         if (state == IDLE && |req_i) gnt <= pick;
         if (state == LOAD) begin
            addr <= xy_g;
            cnt  <= len_c;
         end
         if (hs) begin
            buf_addr_o <= addr;
            buf_data_o <= char_g;
            addr       <= addr + 8'd1;
            cnt        <= cnt - 5'd1;
         end
         // an aborted transfer still passes priority on
         if (state == DONE || (state == XFER && !req_g))
            rr_ptr <= gnt_inc;
      end
   end

endmodule

// File: tb/tb_text_buf_writer_arb.sv
// Scoreboard bench for text_buf_writer_arb: clients feed char queues,
// a monitor pops expected writes/done pulses as the DUT emits them.
module tb_text_buf_writer_arb;
   localparam int N = 3;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic sel = 1'b0;
   logic vblank = 1'b0;
   logic [N-1:0]   req_i = '0;
   logic [N-1:0]   valid_i = '0;
   logic [N*8-1:0] xy_i = '0;
   logic [N*5-1:0] len_i = '0;
   logic [N*7-1:0] chr_i = '0;

   logic [N-1:0] rdy0, rdy1, dn0, dn1;
   logic         bz0, bz1, we0, we1;
   logic [7:0]   ad0, ad1;
   logic [6:0]   da0, da1;

   logic [N-1:0] m_rdy, m_dn;
   logic         m_bz, m_we;
   logic [7:0]   m_ad;
   logic [6:0]   m_da;

   assign m_rdy = sel ? rdy1 : rdy0;
   assign m_dn  = sel ? dn1  : dn0;
   assign m_bz  = sel ? bz1  : bz0;
   assign m_we  = sel ? we1  : we0;
   assign m_ad  = sel ? ad1  : ad0;
   assign m_da  = sel ? da1  : da0;

   always #5 clk = ~clk;

   text_buf_writer_arb #(.N_REQ(N), .BLANK_ONLY(1'b0)) dut0 (
      .clk(clk), .rst(rst), .req_i(req_i), .start_xy_i(xy_i),
      .len_i(len_i), .char_i(chr_i), .valid_i(valid_i),
      .ready_o(rdy0), .done_o(dn0), .busy_o(bz0), .vblank_i(vblank),
      .buf_we_o(we0), .buf_addr_o(ad0), .buf_data_o(da0)
   );

   text_buf_writer_arb #(.N_REQ(N), .BLANK_ONLY(1'b1)) dut1 (
      .clk(clk), .rst(rst), .req_i(req_i), .start_xy_i(xy_i),
      .len_i(len_i), .char_i(chr_i), .valid_i(valid_i),
      .ready_o(rdy1), .done_o(dn1), .busy_o(bz1), .vblank_i(vblank),
      .buf_we_o(we1), .buf_addr_o(ad1), .buf_data_o(da1)
   );

   int checks = 0;
   int errors = 0;
   int cyc = 0;
   int rem [N];
   logic [6:0]  cq [N][$];
   logic [14:0] exp_w [$];
   int          exp_d [$];
   int          wr_cyc [$];
   int          dn_cyc [$];
   logic [N-1:0] hs_pend = '0;
   logic         vb_prev = 1'b0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
      end
   endtask

   always @(posedge clk) cyc++;

   // client model: present queue head, pop on the handshake seen last cycle
   always @(negedge clk) begin
      if (rst) hs_pend = '0;
      for (int k = 0; k < N; k++) begin
         if (hs_pend[k] && cq[k].size() > 0) void'(cq[k].pop_front());
         if (m_dn[k] && rem[k] > 0) rem[k]--;
         req_i[k]   = rem[k] > 0;
         valid_i[k] = cq[k].size() > 0;
         chr_i[7*k +: 7] = (cq[k].size() > 0) ? cq[k][0] : 7'h00;
      end
      #1 hs_pend = m_rdy & valid_i;
   end

   always @(negedge clk) begin
      logic [14:0] ew;
      int ed;
      #2;
      if (!rst) begin
         if (m_we) begin
            wr_cyc.push_back(cyc);
            if (exp_w.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, none expected", m_ad, m_da);
            end else begin
               ew = exp_w.pop_front();
               chk("write", {m_ad, m_da}, ew);
            end
         end
         if (m_dn != '0) begin
            dn_cyc.push_back(cyc);
            if (exp_d.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: done 0x%0h, none expected", m_dn);
            end else begin
               ed = exp_d.pop_front();
               chk("done_vec", 32'(m_dn), 32'(1) << (ed / 2));
               chk("done_we", 32'(m_we), 32'(ed % 2));
            end
         end
         if (sel && !vblank) chk("ready_blank", 32'(m_rdy), 0);
         if (sel && !vblank && !vb_prev) chk("we_blank", 32'(m_we), 0);
      end
      vb_prev = vblank;
   end

   task automatic flush();
      exp_w.delete();
      exp_d.delete();
      for (int k = 0; k < N; k++) begin
         rem[k] = 0;
         cq[k].delete();
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      flush();
      #1;
      chk("rst_ready", 32'(m_rdy), 0);
      chk("rst_done", 32'(m_dn), 0);
      chk("rst_busy", 32'(m_bz), 0);
      chk("rst_we", 32'(m_we), 0);
      chk("rst_addr", 32'(m_ad), 0);
      chk("rst_data", 32'(m_da), 0);
      repeat (2) @(posedge clk);
      #2 rst = 1'b0;
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic issue(input int k, input logic [7:0] xy, input int ln,
                        input int nc, input logic [6:0] c0, input bit with_done);
      int nw;
      nw = (ln > 16) ? 16 : ln;
      if (nc < nw) nw = nc;
      xy_i[8*k +: 8]  = xy;
      len_i[5*k +: 5] = 5'(ln);
      for (int i = 0; i < nc; i++) cq[k].push_back(c0 + 7'(i));
      for (int i = 0; i < nw; i++) exp_w.push_back({xy + 8'(i), c0 + 7'(i)});
      if (with_done) exp_d.push_back(k * 2 + ((ln > 0) ? 1 : 0));
      rem[k]++;
   endtask

   task automatic wait_idle(input int budget);
      bit ok;
      ok = 1'b0;
      for (int i = 0; i < budget; i++) begin
         tick(1);
         if (exp_w.size() == 0 && exp_d.size() == 0 && !m_bz && req_i == '0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL timeout: writes left %0d dones left %0d", exp_w.size(), exp_d.size());
         flush();
      end
   endtask

   initial begin
      int c0;
      #1 do_reset();

      // string write, anytime mode (vblank held low)
      wr_cyc.delete();
      issue(1, 8'h12, 3, 3, 7'h41, 1'b1);
      wait_idle(60);
      chk("t1_consec", (wr_cyc.size() == 3) ? wr_cyc[2] - wr_cyc[0] : -1, 2);

      // round robin 0,1,2,0
      tick(1);
      do_reset();
      dn_cyc.delete();
      issue(0, 8'h20, 1, 1, 7'h61, 1'b1);
      issue(1, 8'h30, 1, 1, 7'h62, 1'b1);
      issue(2, 8'h40, 1, 1, 7'h63, 1'b1);
      issue(0, 8'h20, 1, 1, 7'h64, 1'b1);
      wait_idle(100);
      chk("t2_ndone", dn_cyc.size(), 4);
      if (dn_cyc.size() == 4)
         for (int i = 1; i < 4; i++) chk("t2_gap", dn_cyc[i] - dn_cyc[i-1], 4);

      // zero length, then clamp
      dn_cyc.delete();
      c0 = cyc;
      issue(0, 8'h33, 0, 0, 7'h00, 1'b1);
      wait_idle(30);
      chk("t3_len0_lat", (dn_cyc.size() > 0) ? dn_cyc[0] - c0 : -1, 2);
      issue(2, 8'h00, 20, 20, 7'h30, 1'b1);
      wait_idle(100);
      cq[2].delete();

      // address wrap
      issue(0, 8'hFE, 4, 4, 7'h57, 1'b1);
      wait_idle(60);

      // abort after two chars, client 0 follows
      tick(1);
      do_reset();
      issue(1, 8'h50, 5, 2, 7'h70, 1'b0);
      tick(8);
      issue(0, 8'h60, 1, 1, 7'h7A, 1'b1);
      rem[1] = 0;
      wait_idle(60);
      cq[1].delete();

      // reset while streaming
      issue(2, 8'h70, 8, 8, 7'h30, 1'b1);
      tick(5);
      do_reset();

      // blank-only instance, vblank gap mid-string
      tick(1);
      sel = 1'b1;
      vblank = 1'b1;
      do_reset();
      wr_cyc.delete();
      issue(0, 8'h80, 6, 6, 7'h48, 1'b1);
      for (int i = 0; i < 50; i++) begin
         tick(1);
         if (wr_cyc.size() >= 2) break;
      end
      chk("t5_started", 32'(wr_cyc.size() >= 2), 1);
      vblank = 1'b0;
      tick(10);
      vblank = 1'b1;
      wait_idle(60);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
